// File: rtl/line_buffer_3row.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_3row
// Description : Raster-to-window front end for 3x3 kernel filters. Stores the
//               two previous image lines in internal line RAMs and presents
//               three vertically aligned pixels per accepted beat.
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   pix_valid  in   beat qualifier (no backpressure)
//   pix_sof    in   start of frame, marks pixel (0,0), sampled with pix_valid
//   pix_data   in   8-bit pixel
//   r0/r1/r2   out  pixels at (row-2,col), (row-1,col), (row,col)
//   en         out  complete 3x3 neighbourhood available
//   win_row    out  window centre row (row-1), valid with en
//   win_col    out  window centre column (col-1), valid with en
//   frame_done out  pulse with the last beat of the frame
//   sof_err    out  pulse when pix_sof restarts a frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_3row #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int COL_W     = $clog2(IMG_WIDTH),
    localparam int ROW_W     = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [7:0]       pix_data,
    output logic [7:0]       r0,
    output logic [7:0]       r1,
    output logic [7:0]       r2,
    output logic             en,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic             frame_done,
    output logic             sof_err
);

    localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_COL_ONE = COL_W'(1);
    localparam logic [ROW_W-1:0] c_ROW_ONE = ROW_W'(1);
    localparam logic [COL_W-1:0] c_COL_TWO = COL_W'(2);
    localparam logic [ROW_W-1:0] c_ROW_TWO = ROW_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] w_row_nxt;

    // Line RAMs: lb0 holds row y-1, lb1 holds row y-2. Not reset; stale
    // contents are never flagged by en.
    logic [7:0] r_lb0 [0:IMG_WIDTH-1];
    logic [7:0] r_lb1 [0:IMG_WIDTH-1];

    logic             w_take;
    logic [COL_W-1:0] w_cur_col;
    logic [ROW_W-1:0] w_cur_row;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_en_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    // A beat is processed when a frame is in progress, or when it carries
    // pix_sof (which always forces the position to (0,0)).
    assign w_take     = pix_valid && (pix_sof || (r_state != S_IDLE));
    assign w_cur_col  = pix_sof ? '0 : r_col;
    assign w_cur_row  = pix_sof ? '0 : r_row;
    assign w_col_last = (w_cur_col == c_COL_MAX);
    assign w_row_last = (w_cur_row == c_ROW_MAX);

    assign w_en_nxt   = w_take && !pix_sof && (r_state == S_RUN) &&
                        (w_cur_row >= c_ROW_TWO) && (w_cur_col >= c_COL_TWO);
    assign w_done_nxt = w_take && !pix_sof && (r_state == S_RUN) &&
                        w_row_last && w_col_last;
    assign w_err_nxt  = pix_valid && pix_sof && (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        if (w_take) begin
            if (w_col_last) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_last ? '0 : (w_cur_row + c_ROW_ONE);
            end else begin
                w_col_nxt = w_cur_col + c_COL_ONE;
                w_row_nxt = w_cur_row;
            end

            if (pix_sof) begin
                w_state_nxt = S_FILL;
            end else begin
                case (r_state)
                    S_FILL: begin
                        if ((w_cur_row == c_ROW_ONE) && w_col_last) begin
                            w_state_nxt = S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_row_last && w_col_last) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Line RAM update; the output register below reads the old contents in
    // the same edge, giving read-before-write behaviour.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb1[w_cur_col] <= r_lb0[w_cur_col];
            r_lb0[w_cur_col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0         <= '0;
            r1         <= '0;
            r2         <= '0;
            win_row    <= '0;
            win_col    <= '0;
            en         <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            en         <= w_en_nxt;
            frame_done <= w_done_nxt;
            sof_err    <= w_err_nxt;
            if (w_take) begin
                r0      <= r_lb1[w_cur_col];
                r1      <= r_lb0[w_cur_col];
                r2      <= pix_data;
                win_row <= w_cur_row - c_ROW_ONE;
                win_col <= w_cur_col - c_COL_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_3row.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_buffer_3row
// Description : Self-checking bench for line_buffer_3row with an 8x6 image.
//               A per-frame vector table holds the ramp pixels and the
//               expected window outputs for every beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buffer_3row;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk;
    logic       rst_n;
    logic       pix_valid;
    logic       pix_sof;
    logic [7:0] pix_data;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       en;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic       frame_done;
    logic       sof_err;

    int n_checks = 0;
    int n_errors = 0;

    line_buffer_3row #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .r0        (r0),
        .r1        (r1),
        .r2        (r2),
        .en        (en),
        .win_row   (win_row),
        .win_col   (win_col),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sof;
        logic [7:0] data;
        logic       en;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [2:0] wr;
        logic [2:0] wc;
        logic       fd;
        logic       chk01;
    } vec_t;

    vec_t tbl [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " r0"}, 32'(r0), 32'd0);
        chk({tag, " r1"}, 32'(r1), 32'd0);
        chk({tag, " r2"}, 32'(r2), 32'd0);
        chk({tag, " en"}, 32'(en), 32'd0);
        chk({tag, " win_row"}, 32'(win_row), 32'd0);
        chk({tag, " win_col"}, 32'(win_col), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, " sof_err"}, 32'(sof_err), 32'd0);
    endtask

    // Drive one cycle on the falling edge, sample 1 time unit after the rise.
    task automatic cycle(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Play table entries first..last with pixel offset off. restart marks the
    // first beat as a mid-frame pix_sof that must raise sof_err. gaps inserts
    // an idle cycle after every two beats.
    task automatic play(input logic [7:0] off, input int first, input int last,
                        input bit gaps, input bit restart, output int n_en);
        logic [7:0] l_r0, l_r1, l_r2;
        logic [2:0] l_wr, l_wc;
        logic       l_chk01, l_en;
        int         k;
        n_en    = 0;
        k       = 0;
        l_chk01 = 1'b0;
        l_en    = 1'b0;
        l_r0 = '0; l_r1 = '0; l_r2 = '0; l_wr = '0; l_wc = '0;
        for (int i = first; i <= last; i++) begin
            cycle(1'b1, tbl[i].sof, tbl[i].data + off);
            if (en === 1'b1) n_en++;
            chk("en", 32'(en), 32'(tbl[i].en));
            chk("frame_done", 32'(frame_done), 32'(tbl[i].fd));
            chk("sof_err", 32'(sof_err), 32'(restart && (i == first)));
            chk("r2", 32'(r2), 32'(8'(tbl[i].data + off)));
            if (tbl[i].chk01) begin
                chk("r0", 32'(r0), 32'(8'(tbl[i].r0 + off)));
                chk("r1", 32'(r1), 32'(8'(tbl[i].r1 + off)));
            end
            if (tbl[i].en) begin
                chk("win_row", 32'(win_row), 32'(tbl[i].wr));
                chk("win_col", 32'(win_col), 32'(tbl[i].wc));
            end
            l_r0 = tbl[i].r0 + off; l_r1 = tbl[i].r1 + off; l_r2 = tbl[i].data + off;
            l_wr = tbl[i].wr; l_wc = tbl[i].wc;
            l_chk01 = tbl[i].chk01; l_en = tbl[i].en;
            k++;
            if (gaps && (k % 2 == 0) && (i != last)) begin
                cycle(1'b0, 1'($urandom), 8'($urandom));
                chk("gap en", 32'(en), 32'd0);
                chk("gap frame_done", 32'(frame_done), 32'd0);
                chk("gap sof_err", 32'(sof_err), 32'd0);
                chk("gap r2 hold", 32'(r2), 32'(l_r2));
                if (l_chk01) begin
                    chk("gap r0 hold", 32'(r0), 32'(l_r0));
                    chk("gap r1 hold", 32'(r1), 32'(l_r1));
                end
                if (l_en) begin
                    chk("gap win_row hold", 32'(win_row), 32'(l_wr));
                    chk("gap win_col hold", 32'(win_col), 32'(l_wc));
                end
            end
        end
    endtask

    initial begin
        int n_en;

        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int idx;
                idx = r * W + c;
                tbl[idx].sof   = (idx == 0);
                tbl[idx].data  = 8'(r * 16 + c);
                tbl[idx].en    = (r >= 2) && (c >= 2);
                tbl[idx].r0    = (r >= 2) ? 8'((r - 2) * 16 + c) : 8'h00;
                tbl[idx].r1    = (r >= 1) ? 8'((r - 1) * 16 + c) : 8'h00;
                tbl[idx].wr    = 3'(r - 1);
                tbl[idx].wc    = 3'(c - 1);
                tbl[idx].fd    = (idx == N - 1);
                tbl[idx].chk01 = (r >= 2);
            end
        end

        // Reset held with random inputs
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 8'h00;
        for (int i = 0; i < 6; i++) begin
            cycle(1'($urandom), 1'($urandom), 8'($urandom));
            chk_zero("in reset");
        end

        // Released, no sof: beats must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
            chk("no sof en", 32'(en), 32'd0);
            chk("no sof r2", 32'(r2), 32'd0);
            chk("no sof frame_done", 32'(frame_done), 32'd0);
        end

        // Contiguous ramp frame
        play(8'h00, 0, N - 1, 1'b0, 1'b0, n_en);
        chk("contiguous en count", 32'(n_en), 32'd24);
        chk("last r0", 32'(r0), 32'h37);
        chk("last r1", 32'(r1), 32'h47);
        chk("last r2", 32'(r2), 32'h57);

        // Beats after the frame without sof produce nothing
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
            chk("post frame en", 32'(en), 32'd0);
            chk("post frame frame_done", 32'(frame_done), 32'd0);
            chk("post frame r2 hold", 32'(r2), 32'h57);
        end

        // Same frame with a gap after every two beats
        play(8'h00, 0, N - 1, 1'b1, 1'b0, n_en);
        chk("gapped en count", 32'(n_en), 32'd24);

        // Mid-frame restart at beat (3,4) with a new offset frame
        play(8'h00, 0, 3 * W + 3, 1'b0, 1'b0, n_en);
        play(8'h80, 0, N - 1, 1'b0, 1'b1, n_en);
        chk("restart en count", 32'(n_en), 32'd24);

        // Asynchronous reset right after beat (4,1)
        play(8'h00, 0, 4 * W + 1, 1'b0, 1'b0, n_en);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
            chk("post reset no sof en", 32'(en), 32'd0);
            chk("post reset no sof r2", 32'(r2), 32'd0);
        end
        play(8'h40, 0, N - 1, 1'b0, 1'b0, n_en);
        chk("post reset en count", 32'(n_en), 32'd24);

        cycle(1'b0, 1'b0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
